// File: rtl/exu_pkg.sv
// rtl/exu_pkg.sv - shared opcodes, CCR bit indices, FSM states and flag-class decode for exu_core
package exu_pkg;

    localparam logic [3:0] OP_ADD   = 4'h0;
    localparam logic [3:0] OP_SUB   = 4'h1;
    localparam logic [3:0] OP_AND   = 4'h2;
    localparam logic [3:0] OP_OR    = 4'h3;
    localparam logic [3:0] OP_SHL   = 4'h4;
    localparam logic [3:0] OP_SHR   = 4'h5;
    localparam logic [3:0] OP_NOT   = 4'h6;
    localparam logic [3:0] OP_PASSB = 4'h7;
    localparam logic [3:0] OP_INC   = 4'h8;
    localparam logic [3:0] OP_DEC   = 4'h9;
    localparam logic [3:0] OP_PASSA = 4'hA;
    localparam logic [3:0] OP_SETC  = 4'hB;
    localparam logic [3:0] OP_CLRC  = 4'hC;
    localparam logic [3:0] OP_MUL   = 4'hD;

    localparam int CCR_C = 2;
    localparam int CCR_N = 1;
    localparam int CCR_Z = 0;

    typedef enum logic {
        IDLE,
        MUL_BUSY
    } exu_state_e;

    typedef enum logic [1:0] {
        FC_ALL,
        FC_NZ,
        FC_NONE,
        FC_C
    } flag_class_e;

    function automatic flag_class_e flag_class(input logic [3:0] op);
        case (op)
            OP_AND, OP_OR, OP_NOT: return FC_NZ;
            OP_PASSA, OP_PASSB:    return FC_NONE;
            OP_SETC, OP_CLRC:      return FC_C;
            default:               return FC_ALL;
        endcase
    endfunction

endpackage

// File: rtl/exu_mul_seq.sv
// rtl/exu_mul_seq.sv - WIDTH-parametrised shift-add multiplier, one partial product per cycle
module exu_mul_seq #(
    parameter int WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 i_start,
    input  logic                 i_flush,
    input  logic [WIDTH-1:0]     i_a,
    input  logic [WIDTH-1:0]     i_b,
    output logic                 o_busy,
    output logic                 o_done,
    output logic [2*WIDTH-1:0]   o_product
);

    localparam int CW = $clog2(WIDTH);

    logic                 r_busy;
    logic [CW-1:0]        r_cnt;
    logic [2*WIDTH-1:0]   r_mcand;
    logic [WIDTH-1:0]     r_mplier;
    logic [2*WIDTH-1:0]   r_acc;
    logic [2*WIDTH-1:0]   w_acc_next;

    assign w_acc_next = r_mplier[0] ? (r_acc + r_mcand) : r_acc;

    // Done and product are presented during the final step so the caller can register them at that edge.
    assign o_busy    = r_busy;
    assign o_done    = r_busy && (r_cnt == '0);
    assign o_product = w_acc_next;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_busy   <= 1'b0;
            r_cnt    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_acc    <= '0;
        end else if (i_flush) begin
            r_busy <= 1'b0;
            r_cnt  <= '0;
        end else if (i_start) begin
            r_busy   <= 1'b1;
            r_cnt    <= CW'(WIDTH - 1);
            r_mcand  <= {{WIDTH{1'b0}}, i_a};
            r_mplier <= i_b;
            r_acc    <= '0;
        end else if (r_busy) begin
            r_acc    <= w_acc_next;
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            r_cnt    <= r_cnt - CW'(1);
            if (r_cnt == '0) begin
                r_busy <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/exu_core.sv
// rtl/exu_core.sv - registered execute stage with internal CCR; EXU_MUL_EN builds the sequential multiplier
module exu_core
    import exu_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int SHW   = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             flush,
    input  logic [3:0]       alu_op,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    input  logic [WIDTH-1:0] imm,
    output logic             out_valid,
    output logic [WIDTH-1:0] result,
    output logic [2:0]       ccr
);

    logic [3:0]         w_op;
    logic [SHW-1:0]     w_amt;
    logic [WIDTH:0]     w_shl;
    logic [WIDTH:0]     w_shr;
    logic [WIDTH:0]     w_wide;
    logic [2:0]         w_ccr_alu;
    logic [2:0]         w_ccr_mul;
    logic               w_accept;
    logic               w_is_mul;
    logic               w_mul_fin;
    logic [2*WIDTH-1:0] w_mul_prod;
    logic               w_unused_imm;
    logic               r_out_valid;
    logic [WIDTH-1:0]   r_result;
    logic [2:0]         r_ccr;

    always_comb begin
        w_op = alu_op;
        if (alu_op > OP_MUL) begin
            w_op = OP_ADD;
        end
`ifndef EXU_MUL_EN
        if (alu_op == OP_MUL) begin
            w_op = OP_ADD;
        end
`endif
    end

    assign w_amt        = imm[SHW-1:0];
    assign w_unused_imm = ^imm[WIDTH-1:SHW];
    // One guard bit catches the last bit shifted out; amounts beyond WIDTH clear it naturally.
    assign w_shl        = {1'b0, src_a} << w_amt;
    assign w_shr        = {src_a, 1'b0} >> w_amt;

    always_comb begin
        w_wide = '0;
        case (w_op)
            OP_ADD:   w_wide = {1'b0, src_a} + {1'b0, src_b};
            OP_SUB:   w_wide = {1'b0, src_b} - {1'b0, src_a};
            OP_AND:   w_wide = {1'b0, src_a & src_b};
            OP_OR:    w_wide = {1'b0, src_a | src_b};
            OP_SHL:   w_wide = w_shl;
            OP_SHR:   w_wide = {w_shr[0], w_shr[WIDTH:1]};
            OP_NOT:   w_wide = {1'b0, ~src_a};
            OP_PASSB: w_wide = {1'b0, src_b};
            OP_INC:   w_wide = {1'b0, src_a} + (WIDTH+1)'(1);
            OP_DEC:   w_wide = {1'b0, src_a} - (WIDTH+1)'(1);
            default:  w_wide = {1'b0, src_a};
        endcase
    end

    always_comb begin
        w_ccr_alu = r_ccr;
        case (flag_class(w_op))
            FC_ALL: begin
                w_ccr_alu[CCR_C] = w_wide[WIDTH];
                w_ccr_alu[CCR_N] = w_wide[WIDTH-1];
                w_ccr_alu[CCR_Z] = (w_wide[WIDTH-1:0] == '0);
            end
            FC_NZ: begin
                w_ccr_alu[CCR_N] = w_wide[WIDTH-1];
                w_ccr_alu[CCR_Z] = (w_wide[WIDTH-1:0] == '0);
            end
            FC_C:    w_ccr_alu[CCR_C] = (w_op == OP_SETC);
            default: w_ccr_alu = r_ccr;
        endcase
    end

    always_comb begin
        w_ccr_mul        = '0;
        w_ccr_mul[CCR_C] = |w_mul_prod[2*WIDTH-1:WIDTH];
        w_ccr_mul[CCR_N] = w_mul_prod[WIDTH-1];
        w_ccr_mul[CCR_Z] = (w_mul_prod[WIDTH-1:0] == '0);
    end

    assign w_accept = in_valid && in_ready && !flush;
    assign w_is_mul = (w_op == OP_MUL);

`ifdef EXU_MUL_EN
    exu_state_e r_state;
    exu_state_e w_state_next;
    logic       w_mul_done;
    logic       w_unused_mul_busy;

    exu_mul_seq #(.WIDTH(WIDTH)) u_mul (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_start   (w_accept && w_is_mul),
        .i_flush   (flush),
        .i_a       (src_a),
        .i_b       (src_b),
        .o_busy    (w_unused_mul_busy),
        .o_done    (w_mul_done),
        .o_product (w_mul_prod)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:     if (w_accept && w_is_mul) w_state_next = MUL_BUSY;
            MUL_BUSY: if (flush || w_mul_done) w_state_next = IDLE;
            default:  w_state_next = IDLE;
        endcase
    end

    assign in_ready  = (r_state == IDLE);
    assign w_mul_fin = (r_state == MUL_BUSY) && w_mul_done;
`else
    assign in_ready   = 1'b1;
    assign w_mul_fin  = 1'b0;
    assign w_mul_prod = '0;
`endif

    // A flush kills both a fresh issue and a multiply finishing in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_result    <= '0;
            r_ccr       <= 3'b000;
        end else begin
            r_out_valid <= 1'b0;
            if (!flush) begin
                if (w_mul_fin) begin
                    r_out_valid <= 1'b1;
                    r_result    <= w_mul_prod[WIDTH-1:0];
                    r_ccr       <= w_ccr_mul;
                end else if (w_accept && !w_is_mul) begin
                    r_out_valid <= 1'b1;
                    r_result    <= w_wide[WIDTH-1:0];
                    r_ccr       <= w_ccr_alu;
                end
            end
        end
    end

    assign out_valid = r_out_valid;
    assign result    = r_result;
    assign ccr       = r_ccr;

endmodule

// File: tb/tb_exu_core.sv
// tb/tb_exu_core.sv - directed self-checking bench for exu_core (MUL scenarios under EXU_MUL_EN)
module tb_exu_core;
    import exu_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        flush = 1'b0;
    logic [3:0]  alu_op = 4'h0;
    logic [15:0] src_a = 16'h0;
    logic [15:0] src_b = 16'h0;
    logic [15:0] imm = 16'h0;
    logic        out_valid;
    logic [15:0] result;
    logic [2:0]  ccr;

    int total = 0;
    int bad = 0;

    exu_core #(.WIDTH(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .flush     (flush),
        .alu_op    (alu_op),
        .src_a     (src_a),
        .src_b     (src_b),
        .imm       (imm),
        .out_valid (out_valid),
        .result    (result),
        .ccr       (ccr)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  op;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] im;
        logic [15:0] res;
        logic [2:0]  cc;
    } vec_t;

    task automatic drive(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                         input logic [15:0] im, input logic fl);
        alu_op = op; src_a = a; src_b = b; imm = im; in_valid = 1'b1; flush = fl;
        @(posedge clk); #1;
        in_valid = 1'b0; flush = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        total++;
        if ({out_valid, result, ccr, in_ready} !== {1'b0, 16'h0000, 3'b000, 1'b1}) begin
            bad++;
            $display("FAIL reset_held: got ov=%b res=%h ccr=%b rdy=%b want 0 0000 000 1", out_valid, result, ccr, in_ready);
        end
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        total++;
        if ({out_valid, result, ccr, in_ready} !== {1'b0, 16'h0000, 3'b000, 1'b1}) begin
            bad++;
            $display("FAIL reset_release: got ov=%b res=%h ccr=%b rdy=%b want 0 0000 000 1", out_valid, result, ccr, in_ready);
        end
    endtask

    task automatic test_add();
        drive(OP_ADD, 16'hFFFF, 16'h0001, 16'h0, 1'b0);
        total++;
        if ({out_valid, result, ccr} !== {1'b1, 16'h0000, 3'b101}) begin
            bad++;
            $display("FAIL add_wrap: got ov=%b res=%h ccr=%b want 1 0000 101", out_valid, result, ccr);
        end
        @(posedge clk); #1;
        total++;
        if ({out_valid, result, ccr} !== {1'b0, 16'h0000, 3'b101}) begin
            bad++;
            $display("FAIL add_pulse: got ov=%b res=%h ccr=%b want 0 0000 101", out_valid, result, ccr);
        end
    endtask

    // Issued back to back, so each row also checks flag chaining from the row before.
    task automatic test_alu_ops();
        vec_t v[$];
        v.push_back('{OP_SUB,   16'h0005, 16'h0003, 16'd0,  16'hFFFE, 3'b110});
        v.push_back('{OP_AND,   16'h00F0, 16'h000F, 16'd0,  16'h0000, 3'b101});
        v.push_back('{OP_SHR,   16'h0003, 16'h0000, 16'd1,  16'h0001, 3'b100});
        v.push_back('{OP_SHL,   16'h8001, 16'h0000, 16'd1,  16'h0002, 3'b100});
        v.push_back('{OP_SHL,   16'h8001, 16'h0000, 16'd17, 16'h0000, 3'b001});
        v.push_back('{OP_SHL,   16'h8001, 16'h0000, 16'd16, 16'h0000, 3'b101});
        v.push_back('{OP_SHR,   16'h8001, 16'h0000, 16'd0,  16'h8001, 3'b010});
        v.push_back('{OP_SETC,  16'h1234, 16'h0000, 16'd0,  16'h1234, 3'b110});
        v.push_back('{OP_SHR,   16'h8001, 16'h0000, 16'd16, 16'h0000, 3'b101});
        v.push_back('{OP_PASSB, 16'h0000, 16'h8000, 16'd0,  16'h8000, 3'b101});
        v.push_back('{OP_CLRC,  16'h0000, 16'h0000, 16'd0,  16'h0000, 3'b001});
        v.push_back('{OP_OR,    16'h8000, 16'h0001, 16'd0,  16'h8001, 3'b010});
        v.push_back('{OP_INC,   16'hFFFF, 16'h0000, 16'd0,  16'h0000, 3'b101});
        v.push_back('{OP_NOT,   16'hFFFF, 16'h0000, 16'd0,  16'h0000, 3'b101});
        v.push_back('{OP_DEC,   16'h0000, 16'h0000, 16'd0,  16'hFFFF, 3'b110});
        v.push_back('{OP_PASSA, 16'h0000, 16'h0000, 16'd0,  16'h0000, 3'b110});
        v.push_back('{4'hE,     16'h0001, 16'h0002, 16'd0,  16'h0003, 3'b000});
        v.push_back('{4'hF,     16'h7FFF, 16'h0001, 16'd0,  16'h8000, 3'b010});
        v.push_back('{OP_SUB,   16'h0003, 16'h0003, 16'd0,  16'h0000, 3'b001});
        foreach (v[i]) begin
            drive(v[i].op, v[i].a, v[i].b, v[i].im, 1'b0);
            total++;
            if ({out_valid, result, ccr} !== {1'b1, v[i].res, v[i].cc}) begin
                bad++;
                $display("FAIL alu_op[%0d] op=%h: got ov=%b res=%h ccr=%b want 1 %h %b",
                         i, v[i].op, out_valid, result, ccr, v[i].res, v[i].cc);
            end
        end
    endtask

    task automatic test_flush();
        drive(OP_ADD, 16'h0001, 16'h0001, 16'h0, 1'b1);
        total++;
        if ({out_valid, result, ccr} !== {1'b0, 16'h0000, 3'b001}) begin
            bad++;
            $display("FAIL flush_kill: got ov=%b res=%h ccr=%b want 0 0000 001", out_valid, result, ccr);
        end
        drive(OP_ADD, 16'h0001, 16'h0001, 16'h0, 1'b0);
        total++;
        if ({out_valid, result, ccr} !== {1'b1, 16'h0002, 3'b000}) begin
            bad++;
            $display("FAIL flush_after: got ov=%b res=%h ccr=%b want 1 0002 000", out_valid, result, ccr);
        end
    endtask

    task automatic test_async_reset();
        drive(OP_ADD, 16'h7FFF, 16'h0001, 16'h0, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        total++;
        if ({out_valid, result, ccr, in_ready} !== {1'b0, 16'h0000, 3'b000, 1'b1}) begin
            bad++;
            $display("FAIL async_reset: got ov=%b res=%h ccr=%b rdy=%b want 0 0000 000 1", out_valid, result, ccr, in_ready);
        end
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        drive(OP_ADD, 16'h0002, 16'h0003, 16'h0, 1'b0);
        total++;
        if ({out_valid, result, ccr} !== {1'b1, 16'h0005, 3'b000}) begin
            bad++;
            $display("FAIL after_reset_add: got ov=%b res=%h ccr=%b want 1 0005 000", out_valid, result, ccr);
        end
    endtask

`ifdef EXU_MUL_EN
    task automatic test_mul();
        int busy_bad;
        logic [15:0] ma [3] = '{16'h0100, 16'h0003, 16'h00FF};
        logic [15:0] mb [3] = '{16'h0100, 16'h0005, 16'h0101};
        logic [15:0] mr [3] = '{16'h0000, 16'h000F, 16'hFFFF};
        logic [2:0]  mc [3] = '{3'b101,   3'b000,   3'b010};
        for (int k = 0; k < 3; k++) begin
            drive(OP_MUL, ma[k], mb[k], 16'h0, 1'b0);
            busy_bad = 0;
            for (int c = 1; c <= 16; c++) begin
                if (in_ready !== 1'b0 || out_valid !== 1'b0) busy_bad++;
                in_valid = 1'b1; alu_op = OP_ADD;
                @(posedge clk); #1;
            end
            in_valid = 1'b0;
            total++;
            if (busy_bad != 0) begin
                bad++;
                $display("FAIL mul_busy[%0d]: got %0d bad busy cycles want 0", k, busy_bad);
            end
            total++;
            if ({out_valid, result, ccr, in_ready} !== {1'b1, mr[k], mc[k], 1'b1}) begin
                bad++;
                $display("FAIL mul_result[%0d]: got ov=%b res=%h ccr=%b rdy=%b want 1 %h %b 1",
                         k, out_valid, result, ccr, in_ready, mr[k], mc[k]);
            end
        end
        drive(OP_ADD, 16'h0001, 16'h0001, 16'h0, 1'b0);
        total++;
        if ({out_valid, result, ccr} !== {1'b1, 16'h0002, 3'b000}) begin
            bad++;
            $display("FAIL mul_then_add: got ov=%b res=%h ccr=%b want 1 0002 000", out_valid, result, ccr);
        end
    endtask

    task automatic test_mul_flush();
        int ov_seen = 0;
        drive(OP_MUL, 16'h0100, 16'h0100, 16'h0, 1'b0);
        repeat (4) @(posedge clk);
        #1 flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        total++;
        if ({out_valid, ccr, in_ready} !== {1'b0, 3'b000, 1'b1}) begin
            bad++;
            $display("FAIL mul_flush: got ov=%b ccr=%b rdy=%b want 0 000 1", out_valid, ccr, in_ready);
        end
        repeat (16) begin
            @(posedge clk); #1;
            if (out_valid !== 1'b0) ov_seen++;
        end
        total++;
        if (ov_seen != 0) begin
            bad++;
            $display("FAIL mul_flush_quiet: got %0d out_valid pulses want 0", ov_seen);
        end
    endtask

    task automatic test_mul_reset();
        int ov_seen = 0;
        drive(OP_ADD, 16'h7FFF, 16'h0001, 16'h0, 1'b0);
        drive(OP_MUL, 16'h0100, 16'h0100, 16'h0, 1'b0);
        repeat (5) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        total++;
        if ({out_valid, result, ccr, in_ready} !== {1'b0, 16'h0000, 3'b000, 1'b1}) begin
            bad++;
            $display("FAIL mul_reset: got ov=%b res=%h ccr=%b rdy=%b want 0 0000 000 1", out_valid, result, ccr, in_ready);
        end
        @(negedge clk); rst_n = 1'b1;
        repeat (18) begin
            @(posedge clk); #1;
            if (out_valid !== 1'b0 || in_ready !== 1'b1) ov_seen++;
        end
        total++;
        if (ov_seen != 0) begin
            bad++;
            $display("FAIL mul_reset_quiet: got %0d bad cycles want 0", ov_seen);
        end
    endtask
`else
    int rdy_low = 0;
    always @(negedge clk) if (rst_n && in_ready !== 1'b1) rdy_low++;

    task automatic test_op_d_as_add();
        drive(OP_MUL, 16'h0002, 16'h0003, 16'h0, 1'b0);
        total++;
        if ({out_valid, result, ccr, in_ready} !== {1'b1, 16'h0005, 3'b000, 1'b1}) begin
            bad++;
            $display("FAIL op_d_add: got ov=%b res=%h ccr=%b rdy=%b want 1 0005 000 1", out_valid, result, ccr, in_ready);
        end
        total++;
        if (rdy_low != 0) begin
            bad++;
            $display("FAIL ready_const: got %0d cycles with in_ready low want 0", rdy_low);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_add();
        test_alu_ops();
        test_flush();
        test_async_reset();
`ifdef EXU_MUL_EN
        test_mul();
        test_mul_flush();
        test_mul_reset();
`else
        test_op_d_as_add();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
